// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI bridge front end.
// AR FSM encodings, default read ids and the write-engine command code.
package axi_bridge_pkg;

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_BUSY = 1'b1;

  localparam logic [3:0] INST_ARID_DEF = 4'd0;
  localparam logic [3:0] DATA_ARID_DEF = 4'd1;

  localparam logic [1:0] WR_CMD = 2'b01;

  function automatic logic [2:0] to_arsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/wr_addr_fifo.sv
// Circular FIFO of outstanding write word addresses.
// A parallel compare port flags reads that hit a pending write.
module wr_addr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic [29:0] push_addr,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  input  logic [29:0] cmp_addr,
  output logic        hit
);

  localparam int AW = $clog2(DEPTH);

  logic [29:0]      mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push_ok;
  logic             pop_ok;

  assign full    = &vld;
  assign empty   = ~|vld;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld <= '0;
      wp  <= '0;
      rp  <= '0;
    end else begin
      if (push_ok) begin
        vld[wp] <= 1'b1;
        wp      <= wp + 1'b1;
      end
      if (pop_ok) begin
        vld[rp] <= 1'b0;
        rp      <= rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= push_addr;
  end

  // The entry retiring this cycle no longer blocks a read.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem[i] == cmp_addr &&
          !(pop_ok && AW'(i) == rp))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/axi_req_sched.sv
// Request scheduler: arbitrates inst/data reads onto AR,
// issues writes to the write engine and stalls RAW reads.
module axi_req_sched
  import axi_bridge_pkg::*;
#(
  parameter int         WR_DEPTH  = 4,
  parameter logic [3:0] INST_ARID = INST_ARID_DEF,
  parameter logic [3:0] DATA_ARID = DATA_ARID_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  output logic [1:0]  wr_id,
  output logic [31:0] wr_addr,
  output logic [1:0]  wr_size,
  output logic [3:0]  wr_strb,
  output logic [31:0] wr_data,
  input  logic        wr_addr_ok,
  input  logic        bvalid,
  output logic        bready
);

  localparam int CW = $clog2(WR_DEPTH) + 1;

  logic [0:0]    state;
  logic [CW-1:0] wr_cnt;
  logic          cnt_full;
  logic          fifo_full;
  logic          fifo_empty;
  logic          raw_hit;
  logic          b_fire;
  logic          wr_issue;
  logic          d_grant;
  logic          i_grant;

  assign cnt_full = (wr_cnt == CW'(WR_DEPTH));
  // A response with nothing outstanding is dropped.
  assign b_fire   = bvalid & bready &
                    (wr_cnt != '0) & ~fifo_empty;
  assign wr_issue = data_req & data_wr & wr_addr_ok &
                    ~cnt_full & ~fifo_full;

  assign d_grant = (state == AR_IDLE) & data_req &
                   ~data_wr & ~raw_hit;
  assign i_grant = (state == AR_IDLE) & inst_req & ~d_grant;

  assign inst_addr_ok = i_grant;
  assign data_addr_ok = d_grant | wr_issue;
  assign arvalid      = (state == AR_BUSY);

  assign wr_id   = wr_issue ? WR_CMD : 2'b00;
  assign wr_addr = data_addr;
  assign wr_size = data_size;
  assign wr_strb = data_wstrb;
  assign wr_data = data_wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= AR_IDLE;
      arid   <= '0;
      araddr <= '0;
      arsize <= '0;
    end else begin
      unique case (state)
        AR_IDLE: begin
          if (d_grant) begin
            arid   <= DATA_ARID;
            araddr <= data_addr;
            arsize <= to_arsize(data_size);
            state  <= AR_BUSY;
          end else if (i_grant) begin
            arid   <= INST_ARID;
            araddr <= inst_addr;
            arsize <= to_arsize(inst_size);
            state  <= AR_BUSY;
          end
        end
        AR_BUSY: if (arready) state <= AR_IDLE;
        default: state <= AR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_cnt <= '0;
      bready <= 1'b0;
    end else begin
      bready <= 1'b1;
      if (wr_issue && !b_fire)
        wr_cnt <= wr_cnt + 1'b1;
      else if (!wr_issue && b_fire)
        wr_cnt <= wr_cnt - 1'b1;
    end
  end

  wr_addr_fifo #(
    .DEPTH (WR_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (wr_issue),
    .push_addr (data_addr[31:2]),
    .pop       (b_fire),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .cmp_addr  (data_addr[31:2]),
    .hit       (raw_hit)
  );

endmodule
